// File: rtl/fpmul_arbiter.sv
// rtl/fpmul_arbiter.sv - round-robin arbiter sharing one combinational FP multiplier between two requesters
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   req0_valid/ready/a/b        requester 0 operation port (valid/ready handshake)
//   req1_valid/ready/a/b        requester 1 operation port (valid/ready handshake)
//   rsp_valid/ready             response handshake
//   rsp_id/data/flags           requester index, captured product, captured {zero,+inf,-inf,nan}
//   mul_a, mul_b                registered operands driven to the multiplier
//   mul_r, mul_flags            multiplier product and special-case flags
//   ops_done                    saturating count of completed responses

module fpmul_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_flags,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_r,
  input  logic [3:0]  mul_flags,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter is loaded with EXEC_CYCLES-1 so capture happens on the
  // EXEC_CYCLES-th edge after the operands were registered.
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t     state;
  logic       prio;
  logic       id;
  logic [3:0] cnt;
  logic       grant_valid;
  logic       grant_id;

  // prio names the requester that wins a tie; it flips to the loser after every grant.
  always_comb begin
    grant_valid = req0_valid || req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = prio;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && grant_valid && !grant_id;
  assign req1_ready = (state == IDLE) && grant_valid && grant_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      id        <= 1'b0;
      cnt       <= 4'd0;
      mul_a     <= 32'd0;
      mul_b     <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_flags <= 4'd0;
      ops_done  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          // A grant is always a handshake: the granted requester is valid.
          if (grant_valid) begin
            mul_a <= grant_id ? req1_a : req0_a;
            mul_b <= grant_id ? req1_b : req0_b;
            id    <= grant_id;
            prio  <= ~grant_id;
            cnt   <= CNT_INIT;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_data  <= mul_r;
            rsp_flags <= mul_flags;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (ops_done != 16'hFFFF) begin
              ops_done <= ops_done + 16'd1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// tb/tb_fpmul_arbiter.sv - directed self-checking bench for fpmul_arbiter

module tb_fpmul_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp_ready;

  logic        req0_ready_1, req1_ready_1, rsp_valid_1, rsp_id_1;
  logic [31:0] rsp_data_1, mul_a_1, mul_b_1, mul_r_1;
  logic [3:0]  rsp_flags_1, mul_flags_1;
  logic [15:0] ops_done_1;

  logic        req0_ready_4, req1_ready_4, rsp_valid_4, rsp_id_4;
  logic [31:0] rsp_data_4, mul_a_4, mul_b_4, mul_r_4;
  logic [3:0]  rsp_flags_4, mul_flags_4;
  logic [15:0] ops_done_4;

  int n_total = 0;
  int n_pass  = 0;

  // Stand-in multiplier: hand-computed products for the operands used here.
  function automatic logic [35:0] mul_fn(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40000000_40400000: mul_fn = {4'b0000, 32'h40C00000};
      64'h7F800000_3F800000: mul_fn = {4'b0100, 32'h7F800000};
      64'h00000000_40000000: mul_fn = {4'b1000, 32'h00000000};
      64'h3F800000_40800000: mul_fn = {4'b0000, 32'h40800000};
      64'hC0000000_40400000: mul_fn = {4'b0000, 32'hC0C00000};
      default:               mul_fn = {4'b0001, 32'h7FC00000};
    endcase
  endfunction

  assign {mul_flags_1, mul_r_1} = mul_fn(mul_a_1, mul_b_1);
  assign {mul_flags_4, mul_r_4} = mul_fn(mul_a_4, mul_b_4);

  fpmul_arbiter #(.EXEC_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready_1), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready_1), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready), .rsp_id(rsp_id_1),
    .rsp_data(rsp_data_1), .rsp_flags(rsp_flags_1),
    .mul_a(mul_a_1), .mul_b(mul_b_1), .mul_r(mul_r_1), .mul_flags(mul_flags_1),
    .ops_done(ops_done_1)
  );

  fpmul_arbiter #(.EXEC_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready_4), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready_4), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready), .rsp_id(rsp_id_4),
    .rsp_data(rsp_data_4), .rsp_flags(rsp_flags_4),
    .mul_a(mul_a_4), .mul_b(mul_b_4), .mul_r(mul_r_4), .mul_flags(mul_flags_4),
    .ops_done(ops_done_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Present an operation on dut1's port and hold it until granted; returns at the
  // negedge after the handshake with valid dropped.
  task automatic issue(input string tag, input bit who, input logic [31:0] a, input logic [31:0] b);
    bit granted = 1'b0;
    if (who) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else     begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    for (int i = 0; i < 20; i++) begin
      #1;
      if (who ? req1_ready_1 : req0_ready_1) begin granted = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_grant"}, 32'(granted), 32'd1);
    @(negedge clk);
    if (who) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Wait for dut1's response, check it, then consume it.
  task automatic collect(input string tag, input bit exp_id, input logic [31:0] exp_data,
                         input logic [3:0] exp_flags);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid_1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_rsp_valid"}, 32'(seen), 32'd1);
    check({tag, "_rsp_id"}, 32'(rsp_id_1), 32'(exp_id));
    check({tag, "_rsp_data"}, rsp_data_1, exp_data);
    check({tag, "_rsp_flags"}, 32'(rsp_flags_1), 32'(exp_flags));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          nrsp;
    int          bad;
    bit          both;
    bit          saw;
    logic [0:0]  ids [4];
    logic [31:0] datas [4];

    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_rsp_valid", 32'(rsp_valid_1), 32'd0);
    check("rst_rsp_id", 32'(rsp_id_1), 32'd0);
    check("rst_rsp_data", rsp_data_1, 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags_1), 32'd0);
    check("rst_mul_a", mul_a_1, 32'd0);
    check("rst_mul_b", mul_b_1, 32'd0);
    check("rst_ops_done", 32'(ops_done_1), 32'd0);
    check("rst_ready", 32'({req0_ready_1, req1_ready_1}), 32'd0);

    // T1: 2.0 * 3.0, response two cycles after the ready cycle
    req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40400000;
    #1;
    check("t1_req0_ready", 32'(req0_ready_1), 32'd1);
    check("t1_req1_ready", 32'(req1_ready_1), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    check("t1_exec_rsp_valid", 32'(rsp_valid_1), 32'd0);
    check("t1_exec_mul_a", mul_a_1, 32'h40000000);
    check("t1_exec_mul_b", mul_b_1, 32'h40400000);
    check("t1_exec_ready", 32'(req0_ready_1), 32'd0);
    @(negedge clk);
    check("t1_rsp_valid", 32'(rsp_valid_1), 32'd1);
    check("t1_rsp_data", rsp_data_1, 32'h40C00000);
    check("t1_rsp_flags", 32'(rsp_flags_1), 32'd0);
    check("t1_rsp_id", 32'(rsp_id_1), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("t1_rsp_done", 32'(rsp_valid_1), 32'd0);
    check("t1_ops_done", 32'(ops_done_1), 32'd1);

    // T2: both requesters valid from reset, consumer always ready
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40800000;
    req1_valid = 1'b1; req1_a = 32'hC0000000; req1_b = 32'h40400000;
    rsp_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nrsp = 0; both = 1'b0;
    for (int c = 0; c < 80 && nrsp < 4; c++) begin
      @(negedge clk);
      if (req0_ready_1 && req1_ready_1) both = 1'b1;
      if (rsp_valid_1) begin
        ids[nrsp] = rsp_id_1;
        datas[nrsp] = rsp_data_1;
        nrsp++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("t2_nrsp", 32'(nrsp), 32'd4);
    check("t2_both_ready", 32'(both), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_id%0d", k), 32'(ids[k]), 32'(k % 2));
      check($sformatf("t2_data%0d", k), datas[k], (k % 2 == 0) ? 32'h40800000 : 32'hC0C00000);
    end
    check("t2_ops_done", 32'(ops_done_1), 32'd4);

    // T3: response held while consumer stalls
    issue("t3", 1'b1, 32'hC0000000, 32'h40400000);
    for (int i = 0; i < 20 && !rsp_valid_1; i++) @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40800000;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!rsp_valid_1 || rsp_data_1 !== 32'hC0C00000 || rsp_id_1 !== 1'b1 ||
          rsp_flags_1 !== 4'd0 || mul_a_1 !== 32'hC0000000 || mul_b_1 !== 32'h40400000 ||
          req0_ready_1 || req1_ready_1 || ops_done_1 !== 16'd4) bad++;
    end
    check("t3_hold_bad_cycles", 32'(bad), 32'd0);
    check("t3_hold_data", rsp_data_1, 32'hC0C00000);
    check("t3_hold_mul_a", mul_a_1, 32'hC0000000);
    check("t3_hold_ops_done", 32'(ops_done_1), 32'd4);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("t3_ops_done", 32'(ops_done_1), 32'd5);
    check("t3_next_grant", 32'(req0_ready_1), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    collect("t3b", 1'b0, 32'h40800000, 4'b0000);

    // T4: special-case flags pass through
    issue("t4a", 1'b1, 32'h7F800000, 32'h3F800000);
    collect("t4a", 1'b1, 32'h7F800000, 4'b0100);
    issue("t4b", 1'b1, 32'h00000000, 32'h40000000);
    collect("t4b", 1'b1, 32'h00000000, 4'b1000);

    // T5: reset during EXEC on the 4-cycle instance
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40400000;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    check("t5_exec_rsp_valid", 32'(rsp_valid_4), 32'd0);
    check("t5_exec_mul_a", mul_a_4, 32'h40000000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_rst_mul_a", mul_a_4, 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid_4) saw = 1'b1;
    end
    check("t5_no_rsp", 32'(saw), 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("t5_req0_first", 32'(req0_ready_4), 32'd1);
    check("t5_req1_wait", 32'(req1_ready_4), 32'd0);
    check("t5_ops_done", 32'(ops_done_4), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // T6: counter saturation, preloaded near the top
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    force dut1.ops_done = 16'hFFFD;
    @(negedge clk);
    release dut1.ops_done;
    issue("t6a", 1'b0, 32'h40000000, 32'h40400000);
    collect("t6a", 1'b0, 32'h40C00000, 4'b0000);
    check("t6_ops_fffe", 32'(ops_done_1), 32'h0000FFFE);
    issue("t6b", 1'b0, 32'h40000000, 32'h40400000);
    collect("t6b", 1'b0, 32'h40C00000, 4'b0000);
    check("t6_ops_ffff", 32'(ops_done_1), 32'h0000FFFF);
    issue("t6c", 1'b0, 32'h40000000, 32'h40400000);
    collect("t6c", 1'b0, 32'h40C00000, 4'b0000);
    check("t6_ops_sat", 32'(ops_done_1), 32'h0000FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
